// File: rtl/cla_subtractor_pipe.sv
// cla_subtractor_pipe: pipelined WIDTH-bit a - b - bin, one 4-bit CLA group resolved per stage
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, bin on the input side;
//        out_valid/out_ready, diff, bout (plus zero, ovf when SUB_STATUS_EN is defined) on the output side.
// Optional feature macro: SUB_STATUS_EN adds the registered zero and signed-overflow flags.
module cla_subtractor_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_STATUS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             bout
);
  localparam int NSTG = WIDTH / 4;
  logic [NSTG-1:0] v, vi, bw_r, ci, co;
  logic [NSTG:0] adv;
  logic [WIDTH-1:0] a_r [NSTG], b_r [NSTG], r_r [NSTG];
  logic [WIDTH-1:0] ai [NSTG], bi [NSTG], ri [NSTG], rn [NSTG];
  assign adv[NSTG] = ~v[NSTG-1] | out_ready;
  assign in_ready  = adv[0];
  assign out_valid = v[NSTG-1];
  assign diff      = r_r[NSTG-1];
  assign bout      = bw_r[NSTG-1];
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [3:0] p, g, s;
    logic [4:0] c;
    if (k == 0) begin : g_in
      assign ai[k] = a;
      assign bi[k] = b;
      assign ri[k] = '0;
      assign ci[k] = ~bin;
      assign vi[k] = in_valid;
    end else begin : g_link
      assign ai[k] = a_r[k-1];
      assign bi[k] = b_r[k-1];
      assign ri[k] = r_r[k-1];
      assign ci[k] = ~bw_r[k-1];
      assign vi[k] = v[k-1];
    end
    assign p = ai[k][3:0] ^ ~bi[k][3:0];
    assign g = ai[k][3:0] & ~bi[k][3:0];
    assign c[0] = ci[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign s = p ^ c[3:0];
    assign co[k] = c[4];
    // result bits enter at the top and shift down, so the last stage holds diff fully aligned
    assign rn[k] = WIDTH'({s, ri[k]} >> 4);
    assign adv[k] = ~v[k] | adv[k+1];
  end
  // operands shift arithmetically so the next group is always at [3:0] and the MSB survives for ovf
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= '0;
      bw_r <= '0;
      for (int k = 0; k < NSTG; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        r_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (adv[k]) begin
          v[k] <= vi[k];
          if (vi[k]) begin
            a_r[k]  <= $unsigned($signed(ai[k]) >>> 4);
            b_r[k]  <= $unsigned($signed(bi[k]) >>> 4);
            r_r[k]  <= rn[k];
            bw_r[k] <= ~co[k];
          end
        end
      end
    end
  end
`ifdef SUB_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (adv[NSTG-1] && vi[NSTG-1]) begin
      zero <= ~|rn[NSTG-1];
      ovf  <= (ai[NSTG-1][WIDTH-1] ^ bi[NSTG-1][WIDTH-1]) & (rn[NSTG-1][WIDTH-1] ^ ai[NSTG-1][WIDTH-1]);
    end
  end
`endif
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// tb_cla_subtractor_pipe: table vectors, latency/stall/reset sequences and random traffic against a scoreboard
module tb_cla_subtractor_pipe;
  localparam int W = 16;
  typedef struct packed {logic [15:0] d; logic bo, z, o;} res_t;
  typedef struct packed {logic [15:0] a, b; logic bin; res_t r;} vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, bin = 0, out_ready = 1;
  logic in_ready, out_valid, bout;
  logic [W-1:0] a = '0, b = '0, diff;
`ifdef SUB_STATUS_EN
  logic zero, ovf;
`endif
  res_t sb[$];
  res_t cur, e;
  int checks = 0, errors = 0;
  logic stall_q = 0, bo_q = 0, done = 0;
  logic [15:0] d_q = '0;
  vec_t tv [10];
  always #5 clk = ~clk;
  cla_subtractor_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
`ifdef SUB_STATUS_EN
    .zero(zero), .ovf(ovf),
`endif
    .bout(bout));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] t;
    res_t r;
    t = {1'b0, x} - {1'b0, y} - 17'(bi);
    r.d = t[15:0];
    r.bo = t[16];
    r.z = (t[15:0] == 16'h0);
    r.o = (x[15] ^ y[15]) & (t[15] ^ x[15]);
    return r;
  endfunction
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bi, input res_t ex);
    int n = 0;
    logic got;
    a = x; b = y; bin = bi; cur = ex; in_valid = 1;
    do begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1; n++;
    end while (!got && n < 200);
    if (!got) chk("send_timeout", 32'(got), 32'(1));
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'(0));
  endtask
  // monitor at the falling edge: transfers committed at the following rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(cur);
      if (out_valid && stall_q) begin
        chk("stall_hold_diff", 32'(diff), 32'(d_q));
        chk("stall_hold_bout", 32'(bout), 32'(bo_q));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 32'(out_valid), 32'(0));
        else begin
          e = sb.pop_front();
          chk("diff", 32'(diff), 32'(e.d));
          chk("bout", 32'(bout), 32'(e.bo));
`ifdef SUB_STATUS_EN
          chk("zero", 32'(zero), 32'(e.z));
          chk("ovf", 32'(ovf), 32'(e.o));
`endif
        end
      end
      stall_q = out_valid && !out_ready;
      d_q = diff;
      bo_q = bout;
    end else stall_q = 0;
  end
  initial begin
    tv[0] = {16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0};
    tv[1] = {16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tv[2] = {16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tv[3] = {16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    tv[4] = {16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tv[5] = {16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tv[6] = {16'h1234, 16'hFFFF, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0};
    tv[7] = {16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    tv[8] = {16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    tv[9] = {16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_bout", 32'(bout), 32'(0));
`ifdef SUB_STATUS_EN
    chk("rst_zero", 32'(zero), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge clk) rst_n = 1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    send(tv[0].a, tv[0].b, tv[0].bin, tv[0].r);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("latency_out_valid", 32'(out_valid), 32'(i == 3));
    end
    for (int i = 1; i < 10; i++) send(tv[i].a, tv[i].b, tv[i].bin, tv[i].r);
    drain();
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'h1111 * 16'(i + 1), 16'h0F0F, 1'(i), model(16'h1111 * 16'(i + 1), 16'h0F0F, 1'(i)));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'(0));
        chk("stall_out_valid", 32'(out_valid), 32'(1));
        chk("stall_in_flight", 32'(sb.size()), 32'(4));
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("burst_out_valid", 32'(out_valid), 32'(1));
        end
      end
    join
    drain();
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(tv[i].a, tv[i].b, tv[i].bin, tv[i].r);
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("rst_pre_valid", 32'(out_valid), 32'(1));
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_diff", 32'(diff), 32'(0));
    chk("midrst_bout", 32'(bout), 32'(0));
`ifdef SUB_STATUS_EN
    chk("midrst_zero", 32'(zero), 32'(0));
    chk("midrst_ovf", 32'(ovf), 32'(0));
`endif
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale_output", 32'(out_valid), 32'(0));
    end
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [15:0] x, y;
          logic bi;
          x = 16'($urandom); y = 16'($urandom); bi = 1'($urandom_range(0, 1));
          send(x, y, bi, model(x, y, bi));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
